// File: rtl/serial_display_receiver.sv
// serial_display_receiver: 3-wire MAX7219-style frame receiver and scan driver.
// Define DISPLAY_DECODE_EN to enable Code-B font decode per digit.
module serial_display_receiver #(
  parameter int SCAN_DIV    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_load,
  input  logic       i_serial_din,
  input  logic       i_serial_clk,
  output logic       o_wr_valid,
  output logic [3:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err,
  output logic [7:0] o_segments,
  output logic [7:0] o_digit_en
);
  localparam int SW = $clog2(SCAN_DIV);

  logic [SYNC_STAGES-1:0] ld_sync_q, dn_sync_q, ck_sync_q;
  logic ld_s, dn_s, ck_s;
  logic ld_prev_q, ck_prev_q, din_q;
  logic ld_rise_q, ld_fall_q, ck_rise_q;
  logic [11:0] sr_q;
  logic [4:0]  cnt_q;
  logic        wr_valid_q, err_q;
  logic [3:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  assign ld_s = ld_sync_q[SYNC_STAGES-1];
  assign dn_s = dn_sync_q[SYNC_STAGES-1];
  assign ck_s = ck_sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ld_sync_q <= '0;
      dn_sync_q <= '0;
      ck_sync_q <= '0;
      ld_prev_q <= 1'b0;
      ck_prev_q <= 1'b0;
      din_q     <= 1'b0;
      ld_rise_q <= 1'b0;
      ld_fall_q <= 1'b0;
      ck_rise_q <= 1'b0;
    end else begin
      ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], i_serial_load};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], i_serial_din};
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], i_serial_clk};
      ld_prev_q <= ld_s;
      ck_prev_q <= ck_s;
      din_q     <= dn_s;
      ld_rise_q <= ld_s & ~ld_prev_q;
      ld_fall_q <= ~ld_s & ld_prev_q;
      ck_rise_q <= ck_s & ~ck_prev_q;
    end
  end

  // Only frame bits [11:0] are ever used, so the shifter keeps just those.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= ld_rise_q & (cnt_q == 5'd16);
      err_q      <= ld_rise_q & (cnt_q != 5'd16);
      if (ld_rise_q && cnt_q == 5'd16) begin
        wr_addr_q <= sr_q[11:8];
        wr_data_q <= sr_q[7:0];
      end
      if (ld_fall_q) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else if (ck_rise_q && !ld_prev_q) begin
        sr_q  <= {sr_q[10:0], din_q};
        cnt_q <= (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
      end
    end
  end

  logic [7:0] dig_q [8];
  logic [3:0] int_q;
  logic [2:0] lim_q;
  logic       shut_q, test_q;
`ifdef DISPLAY_DECODE_EN
  logic [7:0] dec_q;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
      int_q  <= '0;
      lim_q  <= 3'd7;
      shut_q <= 1'b0;
      test_q <= 1'b0;
`ifdef DISPLAY_DECODE_EN
      dec_q  <= '0;
`endif
    end else if (wr_valid_q) begin
      unique case (1'b1)
        (wr_addr_q != 4'h0) && (wr_addr_q <= 4'h8):
          dig_q[3'(wr_addr_q - 4'h1)] <= wr_data_q;
`ifdef DISPLAY_DECODE_EN
        wr_addr_q == 4'h9: dec_q  <= wr_data_q;
`endif
        wr_addr_q == 4'hA: int_q  <= wr_data_q[3:0];
        wr_addr_q == 4'hB: lim_q  <= wr_data_q[2:0];
        wr_addr_q == 4'hC: shut_q <= wr_data_q[0];
        wr_addr_q == 4'hF: test_q <= wr_data_q[0];
        default: ;
      endcase
    end
  end

  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    idx_q, idx_d, lim;
  logic [3:0]    pwm_q;
  logic          run;

  always_comb begin
    run    = test_q | shut_q;
    lim    = test_q ? 3'd7 : lim_q;
    slot_d = slot_q + SW'(1);
    idx_d  = idx_q;
    if (!run) begin
      slot_d = '0;
      idx_d  = '0;
    end else if (slot_q == SW'(SCAN_DIV - 1)) begin
      slot_d = '0;
      idx_d  = (idx_q >= lim) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slot_q <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_q + 4'd1;
    end
  end

`ifdef DISPLAY_DECODE_EN
  function automatic logic [7:0] code_b(input logic [7:0] v);
    logic [6:0] s;
    case (v[3:0])
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;
      4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;
      4'hA: s = 7'h01;  4'hB: s = 7'h4F;
      4'hC: s = 7'h37;  4'hD: s = 7'h0E;
      4'hE: s = 7'h67;  default: s = 7'h00;
    endcase
    return {v[7], s};
  endfunction
`endif

  logic [7:0] cur, seg;
  logic       on;

  always_comb begin
    cur = dig_q[idx_q];
`ifdef DISPLAY_DECODE_EN
    seg = dec_q[idx_q] ? code_b(cur) : cur;
`else
    seg = cur;
`endif
    on         = test_q | (shut_q & (pwm_q <= int_q));
    o_digit_en = on ? (8'b1 << idx_q) : 8'h00;
    o_segments = test_q ? 8'hFF : (on ? seg : 8'h00);
  end

  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_frame_err = err_q;
endmodule

// File: tb/tb_serial_display_receiver.sv
// tb_serial_display_receiver: directed frames against a cycle-level display model.
// Build with or without DISPLAY_DECODE_EN.
module tb_serial_display_receiver;
  localparam int DIV = 4;
  localparam int S   = 2;
`ifdef DISPLAY_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, load, din, sck;
  logic       o_wr_valid, o_frame_err;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data, o_segments, o_digit_en;

  always #5 clk = ~clk;

  serial_display_receiver #(.SCAN_DIV(DIV), .SYNC_STAGES(S)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_serial_load(load),
    .i_serial_din (din),
    .i_serial_clk (sck),
    .o_wr_valid   (o_wr_valid),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_frame_err  (o_frame_err),
    .o_segments   (o_segments),
    .o_digit_en   (o_digit_en)
  );

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int nv = 0;
  int ne = 0;

  always @(posedge clk) ncyc <= ncyc + 1;
  always @(negedge clk) begin
    nv <= nv + int'(o_wr_valid);
    ne <= ne + int'(o_frame_err);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, ncyc);
    end
  endtask

  typedef struct {
    int         at;
    bit         ok;
    logic [3:0] a;
    logic [7:0] d;
  } ev_t;
  ev_t q[$];

  logic [7:0] m_dig [8];
  logic [7:0] m_dec, m_data;
  logic [3:0] m_addr;
  int m_int, m_lim, m_shut, m_test;
  int m_slot, m_idx, m_pwm, m_valid, m_err;

  function automatic logic [7:0] font(input logic [7:0] v, input bit dec);
    logic [6:0] s;
    if (!(DEC_EN && dec)) return v;
    case (v[3:0])
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;
      4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;
      4'hA: s = 7'h01;  4'hB: s = 7'h4F;
      4'hC: s = 7'h37;  4'hD: s = 7'h0E;
      4'hE: s = 7'h67;  default: s = 7'h00;
    endcase
    return {v[7], s};
  endfunction

  task automatic model_init();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dec = 0; m_addr = 0; m_data = 0;
    m_int = 0; m_lim = 7; m_shut = 0; m_test = 0;
    m_slot = 0; m_idx = 0; m_pwm = 0;
    m_valid = 0; m_err = 0;
    q.delete();
  endtask

  // Advance the model across one rising clock edge.
  task automatic model_step();
    int lim;
    ev_t ev;
    lim = (m_test != 0) ? 7 : m_lim;
    if (m_test == 0 && m_shut == 0) begin
      m_slot = 0;
      m_idx  = 0;
    end else if (m_slot == DIV - 1) begin
      m_slot = 0;
      m_idx  = (m_idx >= lim) ? 0 : m_idx + 1;
    end else begin
      m_slot++;
    end
    m_pwm = (m_pwm + 1) % 16;
    if (m_valid != 0) begin
      if (m_addr >= 1 && m_addr <= 8) m_dig[m_addr - 1] = m_data;
      else if (m_addr == 9)  m_dec  = m_data;
      else if (m_addr == 10) m_int  = int'(m_data[3:0]);
      else if (m_addr == 11) m_lim  = int'(m_data[2:0]);
      else if (m_addr == 12) m_shut = int'(m_data[0]);
      else if (m_addr == 15) m_test = int'(m_data[0]);
    end
    m_valid = 0;
    m_err   = 0;
    if (q.size() > 0 && q[0].at == ncyc) begin
      ev = q.pop_front();
      if (ev.ok) begin
        m_valid = 1;
        m_addr  = ev.a;
        m_data  = ev.d;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare();
    bit on;
    logic [7:0] en, sg;
    on = (m_test != 0) || (m_shut != 0 && m_pwm <= m_int);
    en = on ? 8'(1 << m_idx) : 8'h00;
    sg = (m_test != 0) ? 8'hFF :
         on ? font(m_dig[m_idx], m_dec[m_idx]) : 8'h00;
    chk("wr_valid", 32'(o_wr_valid), 32'(m_valid));
    chk("frame_err", 32'(o_frame_err), 32'(m_err));
    chk("wr_addr", 32'(o_wr_addr), 32'(m_addr));
    chk("wr_data", 32'(o_wr_data), 32'(m_data));
    chk("digit_en", 32'(o_digit_en), 32'(en));
    chk("segments", 32'(o_segments), 32'(sg));
  endtask

  initial begin
    model_init();
    forever begin
      @(negedge clk);
      if (!rst_n) model_init();
      else model_step();
      compare();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCK = clk/8: four cycles low with data set up, four cycles high.
  task automatic send(input int nb, input logic [31:0] v);
    for (int i = nb - 1; i >= 0; i--) begin
      din = v[i];
      cyc(4);
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
    end
    cyc(4);
    load = 1'b1;
    q.push_back('{at: ncyc + S + 2, ok: (nb == 16),
                  a: v[11:8], d: v[7:0]});
    cyc(8);
    load = 1'b0;
    cyc(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sck = 1'b0;
    din = 1'b0;
    load = 1'b0;
    cyc(3);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int v0, e0, c1, c2, c4, cn, acc, ff;
    logic [7:0] exp_seg;
    do_reset();

    cyc(100);
    chk("idle_seg", 32'(o_segments), 32'h00);
    chk("idle_en", 32'(o_digit_en), 32'h00);

    v0 = nv;
    send(16, 32'h0C01);
    send(16, 32'h0B00);
    send(16, 32'h0A0F);
    send(16, 32'h0155);
    chk("valid_count", 32'(nv - v0), 32'd4);
    chk("last_addr", 32'(o_wr_addr), 32'h1);
    chk("last_data", 32'(o_wr_data), 32'h55);
    chk("disp_en", 32'(o_digit_en), 32'h01);
    chk("disp_seg", 32'(o_segments), 32'h55);

    v0 = nv;
    e0 = ne;
    send(15, 32'h00001234);
    send(17, 32'h00010C00);
    chk("err_count", 32'(ne - e0), 32'd2);
    chk("err_no_valid", 32'(nv - v0), 32'd0);
    chk("err_addr_kept", 32'(o_wr_addr), 32'h1);
    chk("err_data_kept", 32'(o_wr_data), 32'h55);
    chk("err_disp_on", 32'(o_digit_en), 32'h01);

    send(16, 32'h0B02);
    cyc(2);
    c1 = 0; c2 = 0; c4 = 0;
    for (int k = 0; k < 24; k++) begin
      if (o_digit_en == 8'h01) c1++;
      if (o_digit_en == 8'h02) c2++;
      if (o_digit_en == 8'h04) c4++;
      cyc(1);
    end
    chk("scan_d0", 32'(c1), 32'd8);
    chk("scan_d1", 32'(c2), 32'd8);
    chk("scan_d2", 32'(c4), 32'd8);

    send(16, 32'h0B00);
    send(16, 32'h0A03);
    cn = 0;
    for (int k = 0; k < 32; k++) begin
      if (o_digit_en != 8'h00) cn++;
      cyc(1);
    end
    chk("pwm_duty", 32'(cn), 32'd8);

    send(16, 32'h0C00);
    chk("shut_en", 32'(o_digit_en), 32'h00);
    send(16, 32'h0A0F);
    send(16, 32'h0F01);
    acc = 0; ff = 0;
    for (int k = 0; k < 32; k++) begin
      acc |= int'(o_digit_en);
      if (o_segments == 8'hFF) ff++;
      cyc(1);
    end
    chk("test_scan_all", 32'(acc), 32'hFF);
    chk("test_seg_ff", 32'(ff), 32'd32);
    send(16, 32'h0F00);
    cyc(2);
    chk("test_off_seg", 32'(o_segments), 32'h00);
    chk("test_off_en", 32'(o_digit_en), 32'h00);

    for (int i = 15; i >= 8; i--) begin
      din = i[0];
      cyc(4);
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
    end
    do_reset();
    cyc(4);
    chk("rst_seg", 32'(o_segments), 32'h00);
    chk("rst_addr", 32'(o_wr_addr), 32'h0);
    v0 = nv;
    send(16, 32'h0C01);
    send(16, 32'h0A0F);
    send(16, 32'h0B00);
    send(16, 32'h0901);
    send(16, 32'h0185);
    cyc(2);
    chk("post_rst_valid", 32'(nv - v0), 32'd5);
    exp_seg = DEC_EN ? 8'hDB : 8'h85;
    chk("decode_seg", 32'(o_segments), 32'(exp_seg));
    chk("decode_en", 32'(o_digit_en), 32'h01);

    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
